// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipeline stage buffers and their neighbouring stages.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  pipe_cnt_t;   // occupancy 0..8 for the deepest supported buffer

  localparam int    MAX_DEPTH = 8;
  localparam word_t NOP_WORD  = 32'h0;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready bundle for one pipeline stage buffer.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // slave = the buffer itself, master = whatever drives both of its sides
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_stage_buf_ptr_ctr.sv
// Circular-buffer pointer: wraps at DEPTH by explicit compare so odd depths work.
module pipe_ptr_ctr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [PTR_W-1:0] o_ptr
);
  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge CLK) begin
    if (!nRST || i_clr)
      r_ptr <= '0;
    else if (i_en)
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: DEPTH-entry circular FIFO with stall masking and squash flush.
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int DATA_W       = $bits(word_t),
  parameter int DEPTH        = 2,
  parameter int BYPASS_READY = 0,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             stall,
  pipe_stage_buf_if.slave  bus,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_N = 1 << PTR_W;

  logic [MEM_N-1:0][DATA_W-1:0] r_mem;
  logic [CNT_W-1:0]             r_count;
  logic [PTR_W-1:0]             w_rd_ptr, w_wr_ptr;
  logic                         w_nempty, w_not_full, w_bypass;
  logic                         w_push, w_pop;

  assign w_nempty   = (r_count != '0);
  assign w_not_full = (r_count < CNT_W'(DEPTH));
  // Full-but-draining lets a same-cycle refill through; stall blocks the drain so it blocks this too.
  assign w_bypass   = (BYPASS_READY != 0) && bus.out_ready && !stall && w_nempty;

  assign bus.in_ready  = w_not_full || w_bypass;
  assign bus.out_valid = w_nempty && !stall;
  assign bus.out_data  = w_nempty ? r_mem[w_rd_ptr] : DATA_W'(NOP_WORD);

  assign w_push = bus.in_valid  && bus.in_ready  && !flush;
  assign w_pop  = bus.out_valid && bus.out_ready && !flush;

  pipe_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .CLK  (CLK),
    .nRST (nRST),
    .i_clr(flush),
    .i_en (w_pop),
    .o_ptr(w_rd_ptr)
  );

  pipe_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .CLK  (CLK),
    .nRST (nRST),
    .i_clr(flush),
    .i_en (w_push),
    .o_ptr(w_wr_ptr)
  );

  // Storage is never cleared; empty reads are masked to the bubble value instead.
  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[w_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge CLK) begin
    if (!nRST || flush)
      r_count <= '0;
    else if (w_push && !w_pop)
      r_count <= r_count + CNT_W'(1);
    else if (w_pop && !w_push)
      r_count <= r_count - CNT_W'(1);
  end

  assign count = r_count;
endmodule
